num_scan_ctrl: RTL and testbench
================================

// Module: num_scan_ctrl
// PURPOSE
//  Sequencer for the 4-bit prime/multiplier indicator. On a start request it sweeps an
//  inclusive range lo..hi through the indicator, one value per beat. Each value and its
//  classification go out on a valid/ready stream. Per-class totals are held at completion.
//  Sits between a host/testbench command source and any consumer of classified numbers.
// PARAMETERS
//  W      4  value width; fixed at 4, matching the indicator input
//  CNT_W  5  width of each total counter; must hold 2**W = 16
// PORTS
//  clk          in   1        single clock, rising edge
//  reset        in   1        synchronous, active-high
//  start        in   1        start request; accepted only in IDLE
//  lo           in   W        first value of the range; sampled when start is accepted
//  hi           in   W        last value of the range; sampled when start is accepted
//  busy         out  1        high in RUN and DONE
//  out_valid    out  1        current beat is valid
//  out_ready    in   1        consumer accepts the beat
//  out_value    out  W        value of the current beat
//  out_prime    out  1        out_value is in {2,3,5,7,11,13}
//  out_mul      out  5        [4..0] = multiple of 11, 7, 5, 3, 2; value 0 sets all bits
//  done         out  1        one-cycle pulse at the end of a scan
//  err          out  1        one-cycle pulse together with done when lo > hi
//  prime_count  out  CNT_W    number of accepted beats with out_prime=1
//  mul_count    out  5*CNT_W  packed totals; slice k = count of accepted beats with out_mul[k]=1
// BEHAVIOUR
//  - Reset: state=IDLE; busy, out_valid, done, err, out_value, and all counters = 0.
//    Reset mid-scan aborts the scan immediately; there is no partial done.
//  - FSM states are IDLE, RUN, DONE.
//  - IDLE:
//    - start with lo<=hi: latch hi, set cur=lo, clear all counters, go to RUN.
//    - start with lo>hi: clear all counters, go to DONE with err_r=1.
//  - RUN:
//    - out_valid=1; out_value=cur.
//    - out_prime/out_mul are driven by the classifier from register cur, so they are
//      glitch-free and have zero latency relative to out_value.
//  - Handshake (out_valid & out_ready at the clock edge):
//    - add out_prime and each out_mul bit to their counters;
//    - if cur==hi, go to DONE; otherwise cur <= cur+1.
//  - Backpressure: while out_ready=0, cur, out_value, out_prime, out_mul and the counters
//    hold stable. out_valid never drops before the beat is accepted.
//  - DONE: lasts exactly 1 cycle with done=1, and err=err_r; then go to IDLE and clear err_r.
//  - Counters hold their final values in IDLE until the next accepted start.
//  - First beat appears 1 cycle after start is accepted.
//    With out_ready held at 1, the sweep is 1 beat/cycle and done follows the last beat by 1 cycle.
//  - Wrap-around: for hi=15, cur+1 (4-bit) would wrap to 0, but it is never used because
//    the FSM leaves RUN first. Value 0 is never emitted unless lo=0.
//  - start while busy is ignored; lo/hi changes after acceptance have no effect.
//  - Counters cannot overflow: at most 16 beats per scan and CNT_W=5.
// STRUCTURE
//  - Shared include/package num_scan_defs:
//    - state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
//    - out_mul index constants MUL2=0, MUL3=1, MUL5=2, MUL7=3, MUL11=4.
//  - One sub-module: num_classifier. It is the purely combinational prime/multiplier
//    indicator (in[3:0] -> out_prime, out_mul[4:0]), instantiated once on cur.
//  - Everything else lives in this module: FSM, cur/hi registers, counter bank.
// TESTING
//  1 Full range: start lo=0 hi=15, out_ready=1.
//    -> 16 beats 0..15 on consecutive cycles; done one cycle after value 15;
//       prime_count=6; mul_count {2:8, 3:6, 5:4, 7:3, 11:2}; err=0.
//  2 Single value: lo=hi=5.
//    -> one beat: value=5, prime=1, mul=5'b00100; then done;
//       prime_count=1, mul5 count=1, all other counts 0.
//  3 Backpressure: lo=2 hi=4, out_ready low for 3 cycles on each beat.
//    -> out_value holds 2, then 3, then 4 while stalled;
//       prime_count=2, mul2 count=2, mul3 count=1.
//  4 Bad range: lo=9 hi=3.
//    -> next cycle done=1 and err=1; out_valid never asserted; all counts 0; back to IDLE.
//  5 Abort and ignore: run lo=0 hi=15; pulse start while at cur=4; assert reset while at cur=7.
//    -> the start has no effect; cycle after reset: busy=0, out_valid=0, counts 0, no done.
//  6 Top boundary: lo=14 hi=15.
//    -> exactly 2 beats (14 with mul=5'b01001, then 15 with mul=5'b00110); no beat with value 0.

Source files
------------

// File: rtl/num_scan_ctrl_pkg.sv
// Shared definitions for the number-scan sequencer: FSM encoding and
// indices of the multiple-of flags on the classified output.
package num_scan_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int NMUL  = 5;
  localparam int MUL2  = 0;
  localparam int MUL3  = 1;
  localparam int MUL5  = 2;
  localparam int MUL7  = 3;
  localparam int MUL11 = 4;

endpackage

// File: rtl/num_scan_ctrl_classifier.sv
// Purely combinational prime / multiple-of indicator for a 4-bit value.
// Zero is treated as a multiple of every divisor.
module num_classifier
  import num_scan_defs::*;
(
  input  logic [3:0]      value_i,
  output logic            prime_o,
  output logic [NMUL-1:0] mul_o
);

  always_comb begin
    prime_o     = value_i inside {4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13};
    mul_o       = '0;
    mul_o[MUL2]  = ~value_i[0];
    mul_o[MUL3]  = value_i inside {4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15};
    mul_o[MUL5]  = value_i inside {4'd0, 4'd5, 4'd10, 4'd15};
    mul_o[MUL7]  = value_i inside {4'd0, 4'd7, 4'd14};
    mul_o[MUL11] = value_i inside {4'd0, 4'd11};
  end

endmodule

// File: rtl/num_scan_ctrl.sv
// Sweeps lo..hi through the classifier, one value per accepted beat, and
// accumulates per-class totals that stay visible until the next start.
module num_scan_ctrl
  import num_scan_defs::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [W-1:0]          lo,
  input  logic [W-1:0]          hi,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_value,
  output logic                  out_prime,
  output logic [NMUL-1:0]       out_mul,
  output logic                  done,
  output logic                  err,
  output logic [CNT_W-1:0]      prime_count,
  output logic [NMUL*CNT_W-1:0] mul_count,
  output state_t                dbg_state
);

  // Stream handshake: a beat transfers on a rising edge where out_valid and
  // out_ready are both high; out_valid and the beat payload stay stable until then.

  state_t            state_q;
  logic [W-1:0]      cur_q, cur_d;
  logic [W-1:0]      hi_q;
  logic              busy_q, valid_q, done_q, err_q;
  logic [CNT_W-1:0]  prime_cnt_q, prime_cnt_d;
  logic [CNT_W-1:0]  mul_cnt_q [NMUL];
  logic [CNT_W-1:0]  mul_cnt_d [NMUL];
  logic              cls_prime;
  logic [NMUL-1:0]   cls_mul;
  logic              fire;

  num_classifier u_classifier (
    .value_i (cur_q),
    .prime_o (cls_prime),
    .mul_o   (cls_mul)
  );

  assign fire  = valid_q & out_ready;
  assign cur_d = cur_q + W'(1);

  always_comb begin
    prime_cnt_d = prime_cnt_q + {{(CNT_W-1){1'b0}}, cls_prime};
    for (int k = 0; k < NMUL; k++) begin
      mul_cnt_d[k] = mul_cnt_q[k] + {{(CNT_W-1){1'b0}}, cls_mul[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      hi_q        <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      prime_cnt_q <= '0;
      for (int k = 0; k < NMUL; k++) mul_cnt_q[k] <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            prime_cnt_q <= '0;
            for (int k = 0; k < NMUL; k++) mul_cnt_q[k] <= '0;
            busy_q <= 1'b1;
            if (lo <= hi) begin
              cur_q   <= lo;
              hi_q    <= hi;
              valid_q <= 1'b1;
              state_q <= S_RUN;
            end else begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (fire) begin
            prime_cnt_q <= prime_cnt_d;
            for (int k = 0; k < NMUL; k++) mul_cnt_q[k] <= mul_cnt_d[k];
            // Leave before incrementing so hi=15 never wraps cur back to 0.
            if (cur_q == hi_q) begin
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              cur_q <= cur_d;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mul_count = '0;
    for (int k = 0; k < NMUL; k++) begin
      mul_count[k*CNT_W +: CNT_W] = mul_cnt_q[k];
    end
  end

  assign busy        = busy_q;
  assign out_valid   = valid_q;
  assign out_value   = cur_q;
  assign out_prime   = cls_prime;
  assign out_mul     = cls_mul;
  assign done        = done_q;
  assign err         = err_q;
  assign prime_count = prime_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_num_scan_ctrl.sv
// Self-checking bench for num_scan_ctrl: directed scans plus randomized ranges
// and backpressure, checked against an arithmetic reference model.
module tb_num_scan_ctrl;
  localparam int W     = 4;
  localparam int CNT_W = 5;

  logic               clk = 1'b0;
  logic               reset, start, out_ready;
  logic [W-1:0]       lo, hi;
  logic               busy, out_valid, out_prime, done, err;
  logic [W-1:0]       out_value;
  logic [4:0]         out_mul;
  logic [CNT_W-1:0]   prime_count;
  logic [5*CNT_W-1:0] mul_count;
  num_scan_defs::state_t dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  int exp_prime;
  int exp_mul[5];
  int ready_mode;
  int stall_cnt;

  num_scan_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .lo          (lo),
    .hi          (hi),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_value   (out_value),
    .out_prime   (out_prime),
    .out_mul     (out_mul),
    .done        (done),
    .err         (err),
    .prime_count (prime_count),
    .mul_count   (mul_count),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model
  function automatic logic model_prime(input int v);
    return (v == 2) || (v == 3) || (v == 5) || (v == 7) || (v == 11) || (v == 13);
  endfunction

  function automatic logic [4:0] model_mul(input int v);
    int div[5];
    logic [4:0] m;
    div = '{2, 3, 5, 7, 11};
    for (int k = 0; k < 5; k++) m[k] = ((v % div[k]) == 0);
    return m;
  endfunction

  task automatic build_model(input int l, input int h);
    logic [4:0] m;
    exp_q.delete();
    exp_prime = 0;
    for (int k = 0; k < 5; k++) exp_mul[k] = 0;
    for (int v = l; v <= h; v++) begin
      exp_q.push_back(W'(v));
      exp_prime += int'(model_prime(v));
      m = model_mul(v);
      for (int k = 0; k < 5; k++) exp_mul[k] += int'(m[k]);
    end
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_prime_cnt"}, 32'(prime_count), 32'(exp_prime));
    for (int k = 0; k < 5; k++)
      check_eq($sformatf("%s_mul_cnt%0d", tag, k), 32'(mul_count[k*CNT_W +: CNT_W]), 32'(exp_mul[k]));
  endtask

  // Drivers
  task automatic drive_ready();
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (stall_cnt < 3) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready = 1'b1;
          stall_cnt = 0;
        end
      end
    endcase
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; lo = '0; hi = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    exp_prime = 0;
    for (int k = 0; k < 5; k++) exp_mul[k] = 0;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_valid", 32'(out_valid), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_value", 32'(out_value), 0);
    check_eq("rst_state", 32'(dbg_state), 0);
    check_counts("rst");
  endtask

  // Scoreboard-driven scan: every valid cycle is compared to the head of exp_q.
  task automatic run_scan(input int l, input int h, input int mode);
    int n, cyc;
    bit done_seen;
    build_model(l, h);
    n = exp_q.size();
    ready_mode = mode;
    stall_cnt  = 0;
    @(posedge clk); #1;
    lo = W'(l); hi = W'(h); start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; lo = W'($urandom); hi = W'($urandom);
    drive_ready();
    cyc = 0;
    done_seen = 1'b0;
    while (!done_seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (exp_q.size() == 0) check_eq("extra_beat", 32'(out_value), 32'hFFFF_FFFF);
        else begin
          check_eq("beat_value", 32'(out_value), 32'(exp_q[0]));
          check_eq("beat_prime", 32'(out_prime), 32'(model_prime(int'(exp_q[0]))));
          check_eq("beat_mul", 32'(out_mul), 32'(model_mul(int'(exp_q[0]))));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (err && !done) check_eq("err_without_done", 32'(err), 0);
      if (done) begin
        done_seen = 1'b1;
        check_eq("done_err", 32'(err), 32'(l > h));
        check_eq("done_busy", 32'(busy), 1);
        check_eq("beats_left", 32'(exp_q.size()), 0);
        check_counts("done");
        if (mode == 0) check_eq("done_latency", 32'(cyc), 32'(n + 1));
      end else begin
        @(posedge clk); #1;
        drive_ready();
      end
    end
    if (!done_seen) check_eq("done_timeout", 0, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("post_done_pulse", 32'(done), 0);
    check_eq("post_err_pulse", 32'(err), 0);
    check_eq("post_busy", 32'(busy), 0);
    check_eq("post_valid", 32'(out_valid), 0);
    check_counts("idle_hold");
  endtask

  // Full sweep with an ignored start at value 4 and a reset at value 7.
  task automatic abort_test();
    int cyc;
    bit saw7, saw_done;
    build_model(0, 15);
    @(posedge clk); #1;
    lo = 4'd0; hi = 4'd15; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; saw7 = 1'b0; saw_done = 1'b0;
    while (!saw7 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) saw_done = 1'b1;
      if (out_valid && exp_q.size() != 0) begin
        check_eq("abort_value", 32'(out_value), 32'(exp_q[0]));
        void'(exp_q.pop_front());
        if (out_value == 4'd4) begin
          start = 1'b1; lo = 4'd9; hi = 4'd3;
        end
        if (out_value == 4'd7) begin
          saw7  = 1'b1;
          reset = 1'b1;
        end
      end
    end
    check_eq("abort_reached7", 32'(saw7), 1);
    check_eq("abort_no_done", 32'(saw_done), 0);
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    exp_prime = 0;
    for (int k = 0; k < 5; k++) exp_mul[k] = 0;
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_valid", 32'(out_valid), 0);
    check_eq("abort_done", 32'(done), 0);
    check_counts("abort");
    @(negedge clk);
    check_eq("abort_no_late_done", 32'(done), 0);
  endtask

  initial begin
    int l, h, m;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; lo = '0; hi = '0;
    do_reset();
    run_scan(0, 15, 0);
    run_scan(5, 5, 0);
    run_scan(2, 4, 2);
    run_scan(9, 3, 0);
    abort_test();
    run_scan(14, 15, 0);
    for (int i = 0; i < 10; i++) begin
      l = $urandom_range(0, 15);
      h = $urandom_range(0, 15);
      m = $urandom_range(0, 2);
      run_scan(l, h, m);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
